mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage MIPS pipeline.
- Allows one outstanding transaction at a time.
- Data accesses take priority; an anti-starvation counter guarantees fetch progress.
- Raises stall requests toward the pipeline control and hazard logic while either requester is waiting, and aborts a data-phase transaction on response timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (>=1)
- TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request, held high until i_done
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid with i_done
- i_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held high until d_done
- d_write  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  one-cycle data completion pulse
- err  out  1  completion was a timeout abort, valid with i_done or d_done
- err_sticky  out  1  set by any timeout, cleared only by reset
- mem_valid  out  1  request to memory
- mem_write  out  1  request is a write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables (all ones for reads)
- mem_ready  in  1  memory accepts when mem_valid & mem_ready
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  DATA_W  read data
- if_stall  out  1  freeze IF = i_req & ~i_done (combinational)
- mem_stall  out  1  freeze pipeline = d_req & ~d_done (combinational)

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: mem_valid, mem_write, mem_addr, mem_wdata, mem_be, i_done, d_done, i_rdata, d_rdata, err, err_sticky, streak counter, timeout counter. Reset mid-transaction abandons it: no done pulse, and a later mem_rvalid for it is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - d_req & i_req: grant data if streak < STARVE_LIMIT, else grant fetch.
  - d_req only: grant data. i_req only: grant fetch. Neither: stay in IDLE.
  - On grant, latch owner, write (0 for fetch), addr, wdata, be (all ones for fetch) into mem_* registers. Go to REQ.
  - Streak update: a data grant with i_req high increments streak, saturating at STARVE_LIMIT. A fetch grant, or a data grant with i_req low, clears streak.
- REQ: mem_valid=1 with the latched fields held stable. On mem_ready, next state is WAIT, mem_valid=0 and the timeout counter is cleared. There is no timeout in REQ.
- WAIT:
  - On mem_rvalid, capture mem_rdata into the owner's rdata (stores capture nothing) and go to RESP with the owner's done=1 and err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without rvalid: go to RESP with done=1, err=1, owner rdata=0, err_sticky=1.
- RESP: lasts exactly one cycle with the owner's done=1; no grant is made. Then go to IDLE, with done and err cleared.
- Requester handshake: the requester must drop req in the cycle after done, or it is treated as a new request. Earliest re-grant is in IDLE, i.e. RESP+1.
- Latency: minimum grant-to-done is 3 cycles (IDLE→REQ, mem_ready the same cycle, rvalid the first WAIT cycle, RESP).
- mem_rvalid outside WAIT is ignored. mem_ready outside REQ is ignored.
- If req drops before done, the transaction still completes on the memory side and done still pulses. Requester inputs are sampled only at grant.
- if_stall and mem_stall deassert in the same cycle as the corresponding done.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, mem_ready=1, rvalid 2 cycles later with rdata=0xDEADBEEF → mem_valid for exactly one cycle with addr 0x100, be=0xF, write=0; i_done one cycle with i_rdata=0xDEADBEEF; if_stall high until then.
- Simultaneous requests: i_req and d_req (store 0x200, wdata 0x55AA, be 0x3) both high in the same cycle → data is granted first with mem_write=1, be=0x3; fetch is granted in the IDLE after d_done's RESP.
- Starvation, STARVE_LIMIT=4: i_req held, d_req re-asserted every transaction → exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- Backpressure: mem_ready low 5 cycles in REQ → mem_valid and address stay stable for 6 cycles; no timeout occurs.
- Timeout, TIMEOUT=64: load granted and accepted, no rvalid → d_done and err after 64 WAIT cycles, d_rdata=0, err_sticky=1. A rvalid arriving later in IDLE is ignored.
- Reset asserted in WAIT → next cycle all outputs are 0 and state is IDLE; no done pulse; the late rvalid is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with a
// single outstanding transaction, data priority, fetch anti-starvation and response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                err,
  output logic                err_sticky,
  output logic                mem_valid,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                mem_stall
);

  localparam int BE_W = DATA_W / 8;
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ST_W-1:0] STARVE_Q = ST_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = data stage owns the port
  logic [ST_W-1:0]     streak_q, streak_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic                err_sticky_q, err_sticky_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      streak_q     <= '0;
      tcnt_q       <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      tcnt_q       <= tcnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    tcnt_d       = tcnt_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;

    case (state_q)
      S_IDLE: begin
        // Data wins unless it has already starved a waiting fetch long enough.
        if (d_req && (!i_req || (streak_q < STARVE_Q))) begin
          state_d     = S_REQ;
          owner_d     = 1'b1;
          mem_valid_d = 1'b1;
          mem_write_d = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          if (i_req) begin
            if (streak_q != STARVE_Q) begin
              streak_d = streak_q + ST_W'(1);
            end
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d     = S_REQ;
          owner_d     = 1'b0;
          mem_valid_d = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = {BE_W{1'b1}};
          streak_d    = '0;
        end
      end

      S_REQ: begin
        if (mem_ready) begin
          state_d     = S_WAIT;
          mem_valid_d = 1'b0;
          tcnt_d      = '0;
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          if (owner_q) begin
            d_done_d = 1'b1;
            if (!mem_write_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d      = S_RESP;
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
          if (owner_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign i_rdata    = i_rdata_q;
  assign i_done     = i_done_q;
  assign d_rdata    = d_rdata_q;
  assign d_done     = d_done_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

  // Stalls drop combinationally in the done cycle so the stage advances immediately.
  assign if_stall  = i_req & ~i_done_q;
  assign mem_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation, backpressure,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              err;
  logic              err_sticky;
  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              if_stall;
  logic              mem_stall;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .TIMEOUT(64)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .err_sticky(err_sticky),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    reset = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_done", {i_done, d_done, err, err_sticky}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b0;

    // Fetch only
    i_req = 1; i_addr = 32'h100; mem_ready = 1;
    #1 check("f_stall_pre", if_stall, 1);
    tick();
    check("f_req", {mem_valid, mem_write, mem_be}, {1'b1, 1'b0, 4'hF});
    check("f_addr", mem_addr, 32'h100);
    tick();
    check("f_valid_once", mem_valid, 0);
    check("f_stall_wait", if_stall, 1);
    tick();
    check("f_no_done_yet", i_done, 0);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0;
    check("f_done", {i_done, d_done, err}, 3'b100);
    check("f_rdata", i_rdata, 32'hDEADBEEF);
    check("f_stall_done", if_stall, 0);
    i_req = 0;
    tick();
    check("f_done_pulse", i_done, 0);

    // Simultaneous: data store first, then fetch
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_write = 1; d_addr = 32'h200; d_wdata = 32'h55AA; d_be = 4'h3;
    tick();
    check("s_dreq", {mem_valid, mem_write, mem_be}, {1'b1, 1'b1, 4'h3});
    check("s_daddr", {mem_addr, mem_wdata}, {32'h200, 32'h55AA});
    check("s_stalls", {if_stall, mem_stall}, 2'b11);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h77;
    tick();
    mem_rvalid = 0;
    check("s_ddone", {i_done, d_done, mem_stall}, 3'b010);
    check("s_store_nocap", d_rdata, 0);
    d_req = 0;
    tick();
    check("s_idle", {mem_valid, d_done}, 2'b00);
    tick();
    check("s_ireq", {mem_valid, mem_write, mem_be}, {1'b1, 1'b0, 4'hF});
    check("s_iaddr", mem_addr, 32'h300);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 0;
    check("s_idone", {i_done, i_rdata}, {1'b1, 32'h12345678});
    i_req = 0;
    tick();

    // Starvation: fetch held, data continuously requesting
    i_req = 1; i_addr = 32'h400;
    d_req = 1; d_write = 0; d_addr = 32'h500;
    for (int g = 0; g < 6; g++) begin
      exp_addr = (g == 4) ? 32'h400 : 32'h500;
      tick();
      check($sformatf("st_grant%0d", g), mem_addr, exp_addr);
      tick();
      mem_rvalid = 1; mem_rdata = 32'hA0 + g;
      tick();
      mem_rvalid = 0;
      if (g == 4) check($sformatf("st_done%0d", g), {i_done, d_done, i_rdata}, {2'b10, 32'hA4});
      else        check($sformatf("st_done%0d", g), {i_done, d_done, d_rdata}, {2'b01, 32'hA0 + g});
      if (g == 5) begin i_req = 0; d_req = 0; end
      tick();
    end

    // Backpressure: ready low for 5 REQ cycles
    mem_ready = 0;
    d_req = 1; d_write = 1; d_addr = 32'h600; d_wdata = 32'hCAFE; d_be = 4'hF;
    tick();
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("bp_hold%0d", k), {mem_valid, mem_addr}, {1'b1, 32'h600});
      tick();
    end
    mem_ready = 1;
    check("bp_hold6", {mem_valid, mem_addr}, {1'b1, 32'h600});
    tick();
    check("bp_accepted", mem_valid, 0);
    tick(); tick();
    mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
    check("bp_done", {d_done, err, err_sticky}, 3'b100);
    d_req = 0;
    tick();

    // Timeout on a load
    d_req = 1; d_write = 0; d_addr = 32'h700;
    tick();
    tick();
    for (int w = 1; w < 64; w++) tick();
    check("to_not_early", d_done, 0);
    tick();
    check("to_done", {d_done, err, err_sticky}, 3'b111);
    check("to_rdata", d_rdata, 0);
    d_req = 0;
    tick();
    check("to_err_clr", {d_done, err, err_sticky}, 3'b001);
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 0;
    check("to_late_rvalid", {d_done, i_done, mem_valid, d_rdata}, 35'h0);

    // Reset while in WAIT
    d_req = 1; d_write = 0; d_addr = 32'h800;
    tick();
    tick();
    d_req = 0; reset = 1;
    tick();
    reset = 0;
    check("mr_regs", {mem_valid, mem_write, mem_be, err, err_sticky, d_done, i_done}, 0);
    check("mr_data", {mem_addr, i_rdata, d_rdata}, 0);
    mem_rvalid = 1; mem_rdata = 32'h1234;
    tick();
    mem_rvalid = 0;
    check("mr_late1", {d_done, i_done, mem_valid, d_rdata}, 35'h0);
    tick();
    check("mr_late2", {d_done, err}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
